psum_drain: RTL

Output stage directly downstream of the psum BRAM that `accelerator_core` fills. Once a layer's partial sums are final, it reads a contiguous range of psum words through a bram_ctrl read port and streams them out on a valid/ready interface with last-beat marking. Reads are credit-limited, so backpressure never overflows the internal buffer.

---
 rtl/accel_pkg.sv | 42 ++++
 rtl/psum_drain_fifo.sv | 86 ++++++++
 rtl/psum_drain.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// -----------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the accelerator output path.
//   - drain_state_e : psum_drain controller states (IDLE / RUN / DONE)
//   - ACCEL_ADDR_WIDTH / ACCEL_DATA_WIDTH : default psum memory geometry
//   - relu_lane()   : clamps one signed lane to zero when it is negative
// -----------------------------------------------------------------------------
package accel_pkg;

    localparam int ACCEL_ADDR_WIDTH = 32;
    localparam int ACCEL_DATA_WIDTH = 32;

    // Widest lane relu_lane() can handle; narrower lanes are zero-extended
    // into this container and the sign is taken from bit (width-1).
    localparam int RELU_MAX_W = 64;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_RUN  = 2'd1,
        DRAIN_DONE = 2'd2
    } drain_state_e;

    // Returns zero when the lane (of the given width) is negative, else the lane.
    function automatic logic [RELU_MAX_W-1:0] relu_lane(
        input logic [RELU_MAX_W-1:0] lane,
        input int unsigned           width
    );
        logic [RELU_MAX_W-1:0] res;
        res = lane;
        if ((width != 32'd0) && (width <= RELU_MAX_W)) begin
            if (lane[width-32'd1]) begin
                res = '0;
            end else begin
                res = lane;
            end
        end else begin
            res = lane;
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_drain_fifo.sv
// -----------------------------------------------------------------------------
// psum_drain_fifo
// Synchronous show-ahead FIFO. The head word is always presented on rd_data
// straight from the storage registers, so it needs no read latency and stays
// stable until it is popped.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en/wr_data : push (ignored when full)
//   rd_en         : pop the head word (ignored when empty)
//   rd_data       : head word (0 after reset)
//   full, empty   : status
//   count         : number of words held (0..DEPTH)
// -----------------------------------------------------------------------------
module psum_drain_fifo
    import accel_pkg::*;
#(
    parameter int WIDTH = ACCEL_DATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s;
    logic             pop_s;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == CW'(0));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign push_s = wr_en & ~full;
    assign pop_s  = rd_en & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_s) - CW'(pop_s);
        if (push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO state registers; storage is reset so the head reads 0 when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
// Reads a contiguous range of psum words through a bram_ctrl read port and
// streams them out on a valid/ready interface with last-beat marking. Reads
// are credit limited (FIFO occupancy + reads in flight < FIFO_DEPTH), so
// downstream backpressure can never overflow the output FIFO.
//
// Optional feature macro: PSUM_DRAIN_RELU_EN -- when defined, every signed
// BIT_WIDTH lane of mem_odat is clamped to zero if negative before it is
// pushed into the FIFO. When undefined, data passes through unmodified.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   i_start, i_base_addr,
//   i_count                   : start pulse, first address, word count
//   o_busy, o_done, o_err     : busy level, completion pulse, sticky overflow
//   mem_radd, mem_rden        : read request to bram_ctrl (registered)
//   mem_odat, mem_oval        : read data return from bram_ctrl
//   o_tdata, o_tvalid,
//   i_tready, o_tlast         : output stream (driven from the FIFO head)
// -----------------------------------------------------------------------------
module psum_drain
    import accel_pkg::*;
#(
    parameter int ADDR_WIDTH = ACCEL_ADDR_WIDTH,
    parameter int DATA_WIDTH = ACCEL_DATA_WIDTH,
    parameter int BIT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] mem_radd,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_odat,
    input  logic                  mem_oval,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast
);

    localparam int LANES = DATA_WIDTH / BIT_WIDTH;
    localparam int IW    = $clog2(FIFO_DEPTH) + 1;   // inflight / occupancy width
    localparam int SW    = IW + 1;                   // credit sum width

    drain_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           issued_q, issued_d;
    logic [31:0]           accept_q, accept_d;
    logic [IW-1:0]         inflight_q, inflight_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  rden_q, rden_d;
    logic [ADDR_WIDTH-1:0] radd_q, radd_d;

    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [DATA_WIDTH-1:0] fifo_rdata_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [IW-1:0]         fifo_count_s;
    logic                  run_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  hs_s;
    logic                  last_beat_s;
    logic                  credit_ok_s;
    logic                  can_issue_s;
    logic                  oval_dec_s;

    assign run_s       = (state_q == DRAIN_RUN);
    assign push_s      = run_s & mem_oval & ~fifo_full_s;
    // A return with no room is a bram_ctrl protocol violation: drop and flag.
    assign drop_s      = run_s & mem_oval & fifo_full_s;
    assign hs_s        = ~fifo_empty_s & i_tready;
    // The head word's index equals the number of words already accepted.
    assign last_beat_s = (accept_q == (count_q - 32'd1));
    // inflight_q already counts the read currently on mem_rden, so a strict
    // '<' keeps occupancy + inflight <= FIFO_DEPTH at all times.
    assign credit_ok_s = ((SW'(fifo_count_s) + SW'(inflight_q)) < SW'(FIFO_DEPTH));
    assign can_issue_s = run_s & (issued_q < count_q) & credit_ok_s;
    assign oval_dec_s  = mem_oval & (inflight_q != IW'(0));

    // Optional per-lane ReLU on the returning read data (combinational, no latency).
    always_comb begin
`ifdef PSUM_DRAIN_RELU_EN
        logic [RELU_MAX_W-1:0] lane_s;
        lane_s    = '0;
        wr_data_s = mem_odat;
        for (int l = 0; l < LANES; l++) begin
            lane_s = relu_lane(RELU_MAX_W'(mem_odat[l*BIT_WIDTH +: BIT_WIDTH]), BIT_WIDTH);
            wr_data_s[l*BIT_WIDTH +: BIT_WIDTH] = lane_s[BIT_WIDTH-1:0];
        end
`else
        wr_data_s = mem_odat;
        for (int l = 0; l < LANES; l++) begin
            wr_data_s[l*BIT_WIDTH +: BIT_WIDTH] = mem_odat[l*BIT_WIDTH +: BIT_WIDTH];
        end
`endif
    end

    psum_drain_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (wr_data_s),
        .rd_en   (hs_s),
        .rd_data (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Controller next-state: start handling, read issue, credit and accept counters.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        issued_d   = issued_q;
        accept_d   = accept_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        radd_d     = radd_q;
        rden_d     = 1'b0;
        case (state_q)
            DRAIN_IDLE: begin
                if (i_start) begin
                    base_d     = i_base_addr;
                    count_d    = i_count;
                    accept_d   = 32'd0;
                    err_d      = 1'b0;
                    if (i_count != 32'd0) begin
                        // The first read needs no credit check: the FIFO is
                        // empty and nothing is in flight while idle.
                        state_d    = DRAIN_RUN;
                        rden_d     = 1'b1;
                        radd_d     = i_base_addr;
                        issued_d   = 32'd1;
                        inflight_d = IW'(1);
                    end else begin
                        state_d    = DRAIN_DONE;
                        issued_d   = 32'd0;
                        inflight_d = IW'(0);
                    end
                end else begin
                    state_d = DRAIN_IDLE;
                end
            end
            DRAIN_RUN: begin
                inflight_d = inflight_q + IW'(can_issue_s) - IW'(oval_dec_s);
                if (can_issue_s) begin
                    rden_d   = 1'b1;
                    radd_d   = base_q + ADDR_WIDTH'(issued_q);
                    issued_d = issued_q + 32'd1;
                end else begin
                    rden_d   = 1'b0;
                end
                if (drop_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (hs_s) begin
                    accept_d = accept_q + 32'd1;
                    if (last_beat_s) begin
                        state_d = DRAIN_DONE;
                    end else begin
                        state_d = DRAIN_RUN;
                    end
                end else begin
                    accept_d = accept_q;
                end
            end
            DRAIN_DONE: begin
                state_d = DRAIN_IDLE;
            end
            default: begin
                state_d = DRAIN_IDLE;
            end
        endcase
        busy_d = (state_d == DRAIN_RUN);
        done_d = (state_d == DRAIN_DONE);
    end

    // Controller and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DRAIN_IDLE;
            base_q     <= '0;
            count_q    <= 32'd0;
            issued_q   <= 32'd0;
            accept_q   <= 32'd0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rden_q     <= 1'b0;
            radd_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            accept_q   <= accept_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rden_q     <= rden_d;
            radd_q     <= radd_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_err    = err_q;
    assign mem_rden = rden_q;
    assign mem_radd = radd_q;
    assign o_tvalid = ~fifo_empty_s;
    assign o_tdata  = fifo_rdata_s;
    assign o_tlast  = ~fifo_empty_s & last_beat_s;

endmodule
